// File: rtl/ram_dp_pipe.sv
// Dual-port RAM: one byte-enabled write port, one pipelined read port.
// After reset an INIT sweep writes zero to every word, then the RAM turns READY.
// Reads return data after READ_LATENCY (1 or 2) cycles.
// COLLISION_MODE selects what a read returns when it targets the same word as
// a write in the same cycle: 0 returns the old word, 1 returns the merged word.
// Optional feature: define RAM_DP_PIPE_PARITY_EN to store one even-parity bit
// per byte and to add the parity_err output.
module ram_dp_pipe #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDRESS_WIDTH  = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned COLLISION_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dina,
  input  logic [DATA_WIDTH/8-1:0]  wea,
  input  logic                     rea,
  input  logic [ADDRESS_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    doutb,
  output logic                     doutb_valid,
  output logic                     init_done
`ifdef RAM_DP_PIPE_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDRESS_WIDTH;

  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : gen_bad_latency
    $error("ram_dp_pipe: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : gen_bad_width
    $error("ram_dp_pipe: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] sweep_q;
  logic [DATA_WIDTH-1:0]    mem_q [Depth];

  logic [NumBytes-1:0]      wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     rd_acc;
  logic                     collide;
  logic [DATA_WIDTH-1:0]    rd_word;

  logic                     s1_valid_q;
  logic [DATA_WIDTH-1:0]    s1_data_q;

  // The sweep owns the write port during INIT; user writes are ignored there.
  always_comb begin
    wr_en   = wea;
    wr_addr = addra;
    wr_data = dina;
    if (state_q == StInit) begin
      wr_en   = '1;
      wr_addr = sweep_q;
      wr_data = '0;
    end
  end

  assign rd_acc  = (state_q == StReady) && rea;
  assign collide = (COLLISION_MODE == 1) && (state_q == StReady) && (addra == addrb);

  // Array read; write-first mode forwards the enabled bytes of a colliding write.
  always_comb begin
    rd_word = mem_q[addrb];
    if (collide) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wea[b]) rd_word[b*8 +: 8] = dina[b*8 +: 8];
      end
    end
  end

`ifdef RAM_DP_PIPE_PARITY_EN
  logic [NumBytes-1:0] par_q [Depth];
  logic [NumBytes-1:0] wr_par;
  logic [NumBytes-1:0] rd_par;
  logic                rd_perr;
  logic                s1_perr_q;

  // Even parity: stored bit makes the byte plus parity have an even count of ones.
  always_comb begin
    for (int b = 0; b < NumBytes; b++) wr_par[b] = ^wr_data[b*8 +: 8];
  end

  // Compare stored parity (forwarded on collision) against the word being returned.
  always_comb begin
    rd_par = par_q[addrb];
    if (collide) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wea[b]) rd_par[b] = wr_par[b];
      end
    end
    rd_perr = 1'b0;
    for (int b = 0; b < NumBytes; b++) rd_perr = rd_perr | (rd_par[b] ^ (^rd_word[b*8 +: 8]));
  end
`endif

  // Memory array (and parity bits) have no reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NumBytes; b++) begin
      if (wr_en[b]) begin
        mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
`ifdef RAM_DP_PIPE_PARITY_EN
        par_q[wr_addr][b] <= wr_par[b];
`endif
      end
    end
  end

  // INIT/READY control with registered init_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      sweep_q   <= '0;
      init_done <= 1'b0;
    end else if (state_q == StInit) begin
      sweep_q <= sweep_q + 1'b1;
      if (&sweep_q) begin
        state_q   <= StReady;
        init_done <= 1'b1;
      end
    end
  end

  // First read stage: captures the word at the accept edge, holds it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
`ifdef RAM_DP_PIPE_PARITY_EN
      s1_perr_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) s1_data_q <= rd_word;
`ifdef RAM_DP_PIPE_PARITY_EN
      s1_perr_q  <= rd_acc & rd_perr;
`endif
    end
  end

  if (READ_LATENCY == 2) begin : gen_lat2
    // Extra output register stage; doutb only moves when a result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        doutb       <= '0;
        doutb_valid <= 1'b0;
`ifdef RAM_DP_PIPE_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end else begin
        doutb_valid <= s1_valid_q;
        if (s1_valid_q) doutb <= s1_data_q;
`ifdef RAM_DP_PIPE_PARITY_EN
        parity_err  <= s1_perr_q;
`endif
      end
    end
  end else begin : gen_lat1
    assign doutb       = s1_data_q;
    assign doutb_valid = s1_valid_q;
`ifdef RAM_DP_PIPE_PARITY_EN
    assign parity_err  = s1_perr_q;
`endif
  end

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Bench for ram_dp_pipe: two instances share stimulus, one with READ_LATENCY=1
// and read-first collisions, the other with READ_LATENCY=2 and write-first.
// Expected words come from a bench-side memory model via per-instance queues.
module tb_ram_dp_pipe;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 4;
  localparam int unsigned NB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    logic          perr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic [NB-1:0] wea = '0;
  logic          rea = 1'b0;
  logic [AW-1:0] addrb = '0;

  logic [DW-1:0] dout0, dout1;
  logic          vld0, vld1, done0, done1;
  logic          perr0, perr1;

  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic          ready = 1'b0;
  logic [DW-1:0] model [16];
  logic [NB-1:0] pflip [16];
  logic [DW-1:0] last0 = '0, last1 = '0;
  exp_t          q0[$], q1[$];
  exp_t          m0, m1;

  ram_dp_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1), .COLLISION_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .addra(addra), .dina(dina), .wea(wea), .rea(rea), .addrb(addrb),
    .doutb(dout0), .doutb_valid(vld0), .init_done(done0)
`ifdef RAM_DP_PIPE_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  ram_dp_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2), .COLLISION_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .addra(addra), .dina(dina), .wea(wea), .rea(rea), .addrb(addrb),
    .doutb(dout1), .doutb_valid(vld1), .init_done(done1)
`ifdef RAM_DP_PIPE_PARITY_EN
    , .parity_err(perr1)
`endif
  );

`ifndef RAM_DP_PIPE_PARITY_EN
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (vld0) begin
      if (q0.size() == 0) check("l1_spurious_valid", 1, 0);
      else begin
        m0 = q0.pop_front();
        check("l1_data", dout0, m0.data);
        check("l1_latency", cyc, m0.cyc);
`ifdef RAM_DP_PIPE_PARITY_EN
        check("l1_parity_err", perr0, m0.perr);
`endif
        last0 = m0.data;
      end
    end else if (rst_n) begin
      check("l1_hold", dout0, last0);
    end
    if (vld1) begin
      if (q1.size() == 0) check("l2_spurious_valid", 1, 0);
      else begin
        m1 = q1.pop_front();
        check("l2_data", dout1, m1.data);
        check("l2_latency", cyc, m1.cyc);
`ifdef RAM_DP_PIPE_PARITY_EN
        check("l2_parity_err", perr1, m1.perr);
`endif
        last1 = m1.data;
      end
    end else if (rst_n) begin
      check("l2_hold", dout1, last1);
    end
  end

  // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next.
  task automatic drive(input logic [NB-1:0] we, input logic [AW-1:0] aa, input logic [DW-1:0] din,
                       input logic re, input logic [AW-1:0] ab);
    exp_t          e0, e1;
    logic [DW-1:0] mrg;
    wea = we; addra = aa; dina = din; rea = re; addrb = ab;
    if (ready) begin
      mrg = merge(model[aa], din, we);
      if (re) begin
        e0.data = model[ab];
        e0.cyc  = cyc + 1;
        e0.perr = (pflip[ab] != '0);
        e1.data = (aa == ab) ? mrg : model[ab];
        e1.cyc  = cyc + 2;
        e1.perr = (aa == ab) ? ((pflip[ab] & ~we) != '0) : (pflip[ab] != '0);
        q0.push_back(e0);
        q1.push_back(e1);
      end
      model[aa] = mrg;
      pflip[aa] = pflip[aa] & ~we;
    end
    @(posedge clk);
    #1;
    wea = '0; rea = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    for (int i = 0; i < 16; i++) begin
      model[i] = '0;
      pflip[i] = '0;
    end
    #3;
    check("rst_valid_l1", vld0, 0);
    check("rst_valid_l2", vld1, 0);
    check("rst_done_l1", done0, 0);
    check("rst_done_l2", done1, 0);
    check("rst_dout_l1", dout0, 0);
    check("rst_dout_l2", dout1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Cycles 1..16 after release show init_done low, cycle 17 high; traffic is ignored.
  task automatic wait_init();
    for (int c = 1; c <= 16; c++) begin
      check("init_lo_l1", done0, 0);
      check("init_lo_l2", done1, 0);
      drive('1, 4'(c), {DW{1'b1}}, 1'b1, 4'(c));
    end
    check("init_hi_l1", done0, 1);
    check("init_hi_l2", done1, 1);
    ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] pat;
    logic [NB-1:0] rwe;
    @(posedge clk);
    #1;
    apply_reset();
    wait_init();

    // Every word reads zero after the sweep.
    for (int a = 0; a < 16; a++) drive('0, '0, '0, 1'b1, 4'(a));
    drive('0, '0, '0, 1'b0, '0);

    // Full-word write then read.
    pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    drive('1, 4'd3, pat, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 4'd3);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);

    // Same-address collision with half the bytes enabled.
    drive('1, 4'd5, {NB{8'hAA}}, 1'b0, '0);
    drive(16'h00FF, 4'd5, {NB{8'h55}}, 1'b1, 4'd5);
    drive('0, '0, '0, 1'b1, 4'd5);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);

    // Distinct writes then back-to-back reads of 0..3.
    for (int a = 0; a < 4; a++) drive('1, 4'(a), {8{16'(a * 16'h1111 + 16'h0F0F)}}, 1'b0, '0);
    for (int a = 0; a < 4; a++) drive('0, '0, '0, 1'b1, 4'(a));

    // Write and read of different addresses in one cycle.
    drive('1, 4'd7, {4{32'hDEADBEEF}}, 1'b0, '0);
    drive('1, 4'd6, {4{32'h12345678}}, 1'b1, 4'd7);
    drive('0, '0, '0, 1'b1, 4'd6);
    drive('0, '0, '0, 1'b0, '0);

    // Random mixed traffic over a narrow address range to force collisions.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: rwe = '0;
        1: rwe = '1;
        default: rwe = NB'($urandom);
      endcase
      drive(rwe, 4'($urandom_range(0, 5)), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)));
    end
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);

    // Reset with a read in flight, then again mid-sweep at address 7.
    drive('0, '0, '0, 1'b1, 4'd3);
    apply_reset();
    for (int c = 0; c < 7; c++) drive('0, '0, '0, 1'b0, '0);
    apply_reset();
    wait_init();
    for (int a = 0; a < 16; a++) drive('0, '0, '0, 1'b1, 4'(a));
    drive('0, '0, '0, 1'b0, '0);

`ifdef RAM_DP_PIPE_PARITY_EN
    drive('1, 4'd2, {4{32'hC001D00D}}, 1'b0, '0);
    drive('1, 4'd1, {4{32'h0BADF00D}}, 1'b0, '0);
    u_dut0.par_q[2][0] = ~u_dut0.par_q[2][0];
    u_dut1.par_q[2][0] = ~u_dut1.par_q[2][0];
    pflip[2][0] = 1'b1;
    drive('0, '0, '0, 1'b1, 4'd2);
    drive('0, '0, '0, 1'b1, 4'd1);
    drive('0, '0, '0, 1'b0, '0);
`endif

    for (int i = 0; i < 4; i++) drive('0, '0, '0, 1'b0, '0);
    check("drain_l1", q0.size(), 0);
    check("drain_l2", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
